display_update_arbiter: RTL and testbench

DISPLAY_UPDATE_ARBITER -- requirements
Module: display_update_arbiter

---
 rtl/bingo_disp_pkg.sv | 37 +++
 rtl/rr_arbiter2.sv | 19 +
 rtl/display_update_arbiter.sv | 169 ++++++++++++++++
 tb/tb_display_update_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bingo_disp_pkg.sv
// Shared definitions for the bingo display update arbiter: default board
// geometry, request opcodes, FSM state type and a popcount helper used when
// DISPLAY_ARB_COUNT_EN is defined.
package bingo_disp_pkg;

    localparam int CELLS   = 25;
    localparam int NUM_W   = 5;
    localparam int IDX_W   = 5;

    localparam int GNT_LOC = 0;
    localparam int GNT_REM = 1;

    typedef enum logic [1:0] {
        OP_WRNUM  = 2'b00,
        OP_SETC   = 2'b01,
        OP_CLRC   = 2'b10,
        OP_CLRALL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_CLEAR  = 2'd2,
        ST_COMMIT = 2'd3
    } state_e;

    // Board is at most 31 cells, so a 5-bit result cannot wrap.
    function automatic logic [IDX_W-1:0] popcount32(input logic [31:0] v);
        logic [IDX_W-1:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {{(IDX_W-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way arbiter: the flagged requester wins a tie, a lone request always
// wins. Purely combinational; the owner keeps and flips the priority flag.
module rr_arbiter2
    import bingo_disp_pkg::*;
(
    input  logic       req_loc,
    input  logic       req_rem,
    input  logic       prio_rem,
    output logic [1:0] grant
);

    // One-hot grant selection.
    always_comb begin
        grant          = 2'b00;
        grant[GNT_REM] = req_rem & (prio_rem | ~req_loc);
        grant[GNT_LOC] = req_loc & (~prio_rem | ~req_rem);
    end

endmodule

// File: rtl/display_update_arbiter.sv
// Arbitrates local and interboard board-update requests into a shadow board
// and copies the shadow to the live map/circle outputs once per frame_end.
//
// state  | meaning
// IDLE   | wait; commit if pending, else grant one request
// APPLY  | apply latched write/set/clear-circle to the shadow (1 cycle)
// CLEAR  | zero one shadow cell per cycle, all CELLS cells
// COMMIT | copy shadow to live outputs (1 cycle)
//
// Optional: define DISPLAY_ARB_COUNT_EN for a registered circle_count.
module display_update_arbiter
    import bingo_disp_pkg::*;
#(
    parameter int CELLS = bingo_disp_pkg::CELLS,
    parameter int NUM_W = bingo_disp_pkg::NUM_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   loc_valid,
    output logic                   loc_ready,
    input  logic [IDX_W-1:0]       loc_idx,
    input  logic [1:0]             loc_op,
    input  logic [NUM_W-1:0]       loc_data,
    input  logic                   rem_valid,
    output logic                   rem_ready,
    input  logic [IDX_W-1:0]       rem_idx,
    input  logic [1:0]             rem_op,
    input  logic [NUM_W-1:0]       rem_data,
    input  logic                   frame_end,
    output logic [NUM_W*CELLS-1:0] map,
    output logic [CELLS-1:0]       circle,
    output logic                   busy,
    output logic                   idx_err,
    output logic [IDX_W-1:0]       circle_count
);

    localparam logic [IDX_W-1:0] LAST_CELL = IDX_W'(CELLS - 1);
    localparam logic [IDX_W:0]   CELLS_EXT = (IDX_W + 1)'(CELLS);

    state_e                   state_q, state_d;
    logic                     pending_q;
    logic                     prio_rem_q;
    logic [IDX_W-1:0]         idx_q;
    op_e                      op_q;
    logic [NUM_W-1:0]         data_q;
    logic [IDX_W-1:0]         clr_cnt_q;
    logic [NUM_W*CELLS-1:0]   shadow_map;
    logic [CELLS-1:0]         shadow_circle;
    logic [1:0]               grant;
    logic                     grant_en;
    logic [1:0]               sel_op;

    rr_arbiter2 u_arb (
        .req_loc  (loc_valid),
        .req_rem  (rem_valid),
        .prio_rem (prio_rem_q),
        .grant    (grant)
    );

    // Requests are only taken in IDLE with no commit owed; ready is forced low
    // while reset is asserted regardless of the valids.
    assign grant_en = rst && (state_q == ST_IDLE) && !pending_q;
    assign sel_op   = grant[GNT_REM] ? rem_op : loc_op;
    assign busy     = (state_q != ST_IDLE) || pending_q;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Next-state, ready handshake and out-of-range flag.
    always_comb begin
        state_d   = state_q;
        loc_ready = 1'b0;
        rem_ready = 1'b0;
        idx_err   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    state_d = ST_COMMIT;
                end else if (grant_en && (grant != 2'b00)) begin
                    loc_ready = grant[GNT_LOC];
                    rem_ready = grant[GNT_REM];
                    state_d   = (sel_op == OP_CLRALL) ? ST_CLEAR : ST_APPLY;
                end
            end
            ST_APPLY: begin
                idx_err = ({1'b0, idx_q} >= CELLS_EXT);
                state_d = ST_IDLE;
            end
            ST_CLEAR: begin
                if (clr_cnt_q == LAST_CELL) state_d = ST_IDLE;
            end
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Commit bookkeeping, priority rotation, request latch and clear counter.
    // A frame_end landing in COMMIT keeps the flag set so another commit follows.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q  <= 1'b0;
            prio_rem_q <= 1'b1;
            idx_q      <= '0;
            op_q       <= OP_WRNUM;
            data_q     <= '0;
            clr_cnt_q  <= '0;
        end else begin
            if (frame_end)                 pending_q <= 1'b1;
            else if (state_q == ST_COMMIT) pending_q <= 1'b0;
            if (loc_ready || rem_ready) begin
                prio_rem_q <= loc_ready;
                idx_q      <= rem_ready ? rem_idx  : loc_idx;
                op_q       <= op_e'(sel_op);
                data_q     <= rem_ready ? rem_data : loc_data;
            end
            if (state_q == ST_CLEAR) begin
                clr_cnt_q <= (clr_cnt_q == LAST_CELL) ? '0 : clr_cnt_q + 1'b1;
            end
        end
    end

    // Shadow board updates; an out-of-range index matches no cell.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_map    <= '0;
            shadow_circle <= '0;
        end else begin
            for (int i = 0; i < CELLS; i++) begin
                if ((state_q == ST_APPLY) && (idx_q == IDX_W'(i))) begin
                    case (op_q)
                        OP_WRNUM: shadow_map[i*NUM_W +: NUM_W] <= data_q;
                        OP_SETC:  shadow_circle[i] <= 1'b1;
                        OP_CLRC:  shadow_circle[i] <= 1'b0;
                        default:  ;
                    endcase
                end
                if ((state_q == ST_CLEAR) && (clr_cnt_q == IDX_W'(i))) begin
                    shadow_map[i*NUM_W +: NUM_W] <= '0;
                    shadow_circle[i]             <= 1'b0;
                end
            end
        end
    end

    // Live board only moves in COMMIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            map    <= '0;
            circle <= '0;
        end else if (state_q == ST_COMMIT) begin
            map    <= shadow_map;
            circle <= shadow_circle;
        end
    end

`ifdef DISPLAY_ARB_COUNT_EN
    // Count of circled cells, captured alongside the committed circle mask.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                      circle_count <= '0;
        else if (state_q == ST_COMMIT) circle_count <= popcount32(32'(shadow_circle));
    end
`else
    assign circle_count = '0;
`endif

endmodule

// File: tb/tb_display_update_arbiter.sv
// Self-checking bench for display_update_arbiter: a cycle-stepped board model
// checked against the DUT every negedge, plus directed literal expectations.
module tb_display_update_arbiter;

    localparam int CELLS = 25;
    localparam int NUM_W = 5;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   loc_valid = 1'b0, rem_valid = 1'b0;
    logic                   loc_ready, rem_ready;
    logic [4:0]             loc_idx = '0, rem_idx = '0;
    logic [1:0]             loc_op = '0, rem_op = '0;
    logic [NUM_W-1:0]       loc_data = '0, rem_data = '0;
    logic                   frame_end = 1'b0;
    logic [NUM_W*CELLS-1:0] map;
    logic [CELLS-1:0]       circle;
    logic                   busy, idx_err;
    logic [4:0]             circle_count;

    int n_checks = 0;
    int n_fail   = 0;

    display_update_arbiter #(.CELLS(CELLS), .NUM_W(NUM_W)) dut (
        .clk(clk), .rst(rst),
        .loc_valid(loc_valid), .loc_ready(loc_ready), .loc_idx(loc_idx),
        .loc_op(loc_op), .loc_data(loc_data),
        .rem_valid(rem_valid), .rem_ready(rem_ready), .rem_idx(rem_idx),
        .rem_op(rem_op), .rem_data(rem_data),
        .frame_end(frame_end), .map(map), .circle(circle), .busy(busy),
        .idx_err(idx_err), .circle_count(circle_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_work;            // cycles of shadow work still owed by the current request
    bit m_commit;          // live copy happens at the end of this cycle
    bit m_pending, m_prio_rem;
    int m_op, m_idx, m_data, m_clr;
    int sh_num[CELLS];
    bit sh_c[CELLS];
    int lv_num[CELLS];
    bit lv_c[CELLS];
    int lv_cnt;

    function automatic bit m_accepting();
        return (m_work == 0) && !m_commit && !m_pending;
    endfunction

    task automatic m_grants(output bit gl, output bit gr);
        gl = 0; gr = 0;
        if (m_accepting()) begin
            if (loc_valid && rem_valid) begin
                gr = m_prio_rem; gl = !m_prio_rem;
            end else begin
                gl = loc_valid; gr = rem_valid;
            end
        end
    endtask

    task automatic m_reset();
        m_work = 0; m_commit = 0; m_pending = 0; m_prio_rem = 1;
        m_op = 0; m_idx = 0; m_data = 0; m_clr = 0; lv_cnt = 0;
        for (int i = 0; i < CELLS; i++) begin
            sh_num[i] = 0; sh_c[i] = 0; lv_num[i] = 0; lv_c[i] = 0;
        end
    endtask

    always @(posedge clk or negedge rst) begin : model_step
        bit gl, gr, commit_now;
        if (!rst) begin
            m_reset();
        end else begin
            m_grants(gl, gr);
            commit_now = m_commit;
            if (m_commit) begin
                lv_cnt = 0;
                for (int i = 0; i < CELLS; i++) begin
                    lv_num[i] = sh_num[i]; lv_c[i] = sh_c[i];
                    lv_cnt += int'(sh_c[i]);
                end
                m_commit = 0;
            end else if (m_work > 0) begin
                if (m_op == 3) begin
                    sh_num[m_clr] = 0; sh_c[m_clr] = 0; m_clr++;
                end else if (m_idx < CELLS) begin
                    if (m_op == 0) sh_num[m_idx] = m_data;
                    else if (m_op == 1) sh_c[m_idx] = 1;
                    else sh_c[m_idx] = 0;
                end
                m_work--;
            end else if (m_pending) begin
                m_commit = 1;
            end else if (gl || gr) begin
                m_op   = gr ? int'(rem_op)   : int'(loc_op);
                m_idx  = gr ? int'(rem_idx)  : int'(loc_idx);
                m_data = gr ? int'(rem_data) : int'(loc_data);
                m_work = (m_op == 3) ? CELLS : 1;
                m_clr  = 0;
                m_prio_rem = gl;
            end
            if (frame_end) m_pending = 1;
            else if (commit_now) m_pending = 0;
        end
    end

    logic [NUM_W*CELLS-1:0] e_map;
    logic [CELLS-1:0]       e_circ;

    // Every-cycle compare against the model.
    always @(negedge clk) begin : compare
        bit gl, gr;
        if (!rst) begin
            chk("rst_outputs", {loc_ready, rem_ready, busy, idx_err, circle_count, circle, map}, '0);
        end else begin
            m_grants(gl, gr);
            for (int i = 0; i < CELLS; i++) begin
                e_map[i*NUM_W +: NUM_W] = NUM_W'(lv_num[i]);
                e_circ[i] = lv_c[i];
            end
            chk("loc_ready", loc_ready, gl);
            chk("rem_ready", rem_ready, gr);
            chk("busy", busy, (m_work != 0) || m_commit || m_pending);
            chk("idx_err", idx_err, (m_work == 1) && !m_commit && (m_op != 3) && (m_idx >= CELLS));
            chk("map", map, e_map);
            chk("circle", circle, e_circ);
`ifdef DISPLAY_ARB_COUNT_EN
            chk("circle_count", circle_count, lv_cnt);
`else
            chk("circle_count", circle_count, 0);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic frame();
        frame_end = 1; tick(1); frame_end = 0;
    endtask

    function automatic int fld(input int i);
        return int'(map[i*NUM_W +: NUM_W]);
    endfunction

    // Presents requests and holds them until accepted; returns after the
    // edge of the last handshake. first: 1 = remote granted first, 0 = local.
    task automatic do_reqs(input bit lv, input int li, input int lo, input int ld,
                           input bit rv, input int ri, input int ro, input int rd,
                           output int first);
        bit gl, gr;
        loc_valid = lv; loc_idx = li[4:0]; loc_op = lo[1:0]; loc_data = ld[4:0];
        rem_valid = rv; rem_idx = ri[4:0]; rem_op = ro[1:0]; rem_data = rd[4:0];
        first = -1;
        for (int c = 0; c < 200 && (loc_valid || rem_valid); c++) begin
            @(negedge clk);
            gl = loc_ready; gr = rem_ready;
            if (first < 0 && (gl || gr)) first = gr ? 1 : 0;
            @(posedge clk); #1;
            if (gl) loc_valid = 0;
            if (gr) rem_valid = 0;
        end
        if (loc_valid || rem_valid) begin
            n_checks++; n_fail++;
            $display("FAIL req_timeout actual=still_valid required=accepted");
            loc_valid = 0; rem_valid = 0;
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin : main
        int first;
        loc_valid = 1; rem_valid = 1;
        tick(3);
        @(negedge clk);
        chk("reset_ready", {loc_ready, rem_ready}, 2'b00);
        chk("reset_busy", busy, 0);
        loc_valid = 0; rem_valid = 0;
        @(posedge clk); #1 rst = 1;
        tick(2);

        // simultaneous requests after reset: remote first, then local
        do_reqs(1, 2, 0, 9, 1, 1, 0, 5, first);
        chk("arb_first_after_reset", first, 1);
        do_reqs(1, 4, 0, 3, 1, 5, 0, 4, first);
        chk("arb_prio_back_to_rem", first, 1);
        tick(2); frame(); tick(2);
        @(negedge clk);
        chk("map_idx1", fld(1), 5);
        chk("map_idx2", fld(2), 9);
        chk("map_idx4", fld(4), 3);
        chk("map_idx5", fld(5), 4);

        // write latency: invisible until the commit after frame_end
        do_reqs(1, 7, 0, 19, 0, 0, 0, 0, first);
        tick(5);
        frame_end = 1;
        @(negedge clk); chk("idx7_before_frame", fld(7), 0);
        @(posedge clk); #1 frame_end = 0;
        @(negedge clk); chk("idx7_pending", fld(7), 0); chk("busy_pending", busy, 1);
        tick(1);
        @(negedge clk); chk("idx7_in_commit", fld(7), 0);
        tick(1);
        @(negedge clk); chk("idx7_visible", fld(7), 19);

        // out-of-range remote set-circle
        tick(1);
        do_reqs(0, 0, 0, 0, 1, 30, 1, 0, first);
        @(negedge clk); chk("idx_err_pulse", idx_err, 1);
        tick(1);
        @(negedge clk); chk("idx_err_done", idx_err, 0);
        frame(); tick(2);
        @(negedge clk); chk("circle_after_bad_idx", circle, '0);

        // circles on 0, 6, 12; then a frame_end landing in COMMIT
        do_reqs(1, 0, 1, 0, 0, 0, 0, 0, first);
        do_reqs(1, 6, 1, 0, 0, 0, 0, 0, first);
        do_reqs(0, 0, 0, 0, 1, 12, 1, 0, first);
        frame(); tick(1);
        frame_end = 1; tick(1); frame_end = 0;
        @(negedge clk);
        chk("circle_0x1041", circle, 25'h1041);
`ifdef DISPLAY_ARB_COUNT_EN
        chk("circle_count_3", circle_count, 3);
`else
        chk("circle_count_off", circle_count, 0);
`endif
        chk("busy_second_commit", busy, 1);
        tick(3);

        // boundary indices and mixed requesters
        do_reqs(1, 24, 0, 31, 1, 25, 0, 1, first);
        do_reqs(1, 6, 2, 0, 1, 3, 0, 17, first);
        frame(); tick(2);
        @(negedge clk);
        chk("map_idx24", fld(24), 31);
        chk("map_idx3", fld(3), 17);

        // clear-all with frame_end in CLEAR cycle 10
        do_reqs(1, 0, 3, 0, 0, 0, 0, 0, first);
        for (int c = 1; c <= CELLS; c++) begin
            if (c == 10) frame_end = 1;
            @(negedge clk); chk("busy_in_clear", busy, 1);
            @(posedge clk); #1 frame_end = 0;
        end
        @(negedge clk); chk("no_partial_circle", circle, 25'h1001);
        tick(2);
        @(negedge clk);
        chk("clear_map", map, '0);
        chk("clear_circle", circle, '0);
        chk("clear_count", circle_count, 0);

        // reset in the middle of APPLY
        do_reqs(1, 8, 0, 11, 0, 0, 0, 0, first);
        frame(); tick(2);
        @(negedge clk); chk("map_idx8", fld(8), 11);
        tick(1);
        do_reqs(1, 3, 0, 7, 0, 0, 0, 0, first);
        #3 rst = 0;
        #1;
        chk("rst_map", map, '0);
        chk("rst_flags", {busy, idx_err, loc_ready, rem_ready, circle_count, circle}, '0);
        @(posedge clk); #1 rst = 1;
        tick(2); frame(); tick(2);
        @(negedge clk);
        chk("lost_request", fld(3), 0);

        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
